ysyx_23060072_stage_buffer: RTL and testbench

Parametrised inter-stage pipeline buffer that replaces the fixed-width, single-entry ID→EX register with a DEPTH-entry valid/ready FIFO. Control fields (CTRL_W) return to a bubble value on reset and flush. Data fields (DATA_W) are plain storage. It keeps the controller's hold and clean (flush) semantics and adds backpressure, occupancy reporting and an optional full-throughput ready path. It can be instantiated between any two pipeline stages (IF/ID, ID/EX, EX/LSU).

---
 rtl/ysyx_23060072_stage_buffer.sv | 68 ++++++
 tb/tb_ysyx_23060072_stage_buffer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/ysyx_23060072_stage_buffer.sv
// ysyx_23060072_stage_buffer: DEPTH-entry valid/ready pipeline buffer with hold, flush and bubble control
module ysyx_23060072_stage_buffer #(
   parameter int                CTRL_W      = 16,
   parameter int                DATA_W      = 128,
   parameter int                DEPTH       = 2,
   parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
   parameter bit                PASS_READY  = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CTRL_W-1:0]            in_ctrl,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CTRL_W-1:0]            out_ctrl,
   output logic [DATA_W-1:0]            out_data,
   input  logic                         hold_i,
   input  logic                         flush_i,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   logic [CTRL_W-1:0] ctrl_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [CW-1:0]     count;
   logic              enq, deq;

   // handshake decode and head presentation; the full-buffer bypass only exists when PASS_READY is set
   always_comb begin
      out_valid = count != '0;
      in_ready  = !hold_i && !flush_i && (count != FULL || (PASS_READY && out_ready));
      enq       = in_valid && in_ready;
      deq       = out_valid && out_ready && !hold_i;
      out_ctrl  = out_valid ? ctrl_mem[rd_ptr] : CTRL_BUBBLE;
      out_data  = data_mem[rd_ptr];
      count_o   = count;
   end

   // storage and pointers: reset clears everything, flush only rewinds, hold freezes
   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         ctrl_mem <= '{default: '0};
         data_mem <= '{default: '0};
      end else if (flush_i) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (!hold_i) begin
         if (enq) begin
            ctrl_mem[wr_ptr] <= in_ctrl;
            data_mem[wr_ptr] <= in_data;
            wr_ptr           <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
         end
         if (deq) rd_ptr <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
         if (enq && !deq) count <= count + 1'b1;
         else if (!enq && deq) count <= count - 1'b1;
      end
   end
endmodule

// File: tb/tb_ysyx_23060072_stage_buffer.sv
// tb_ysyx_23060072_stage_buffer: queue-model scoreboard across several DEPTH/PASS_READY configurations
module tb_ysyx_23060072_stage_buffer;
   localparam int NCFG = 5;
   localparam logic [7:0] BUB = 8'h5A;

   logic clk = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   done_cnt = 0;

   always #5 clk = ~clk;

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cfg%0d t=%0t actual=%h expected=%h", name, g, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < NCFG; g++) begin : cfg
      localparam int D   = g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : g == 3 ? 1 : 5;
      localparam bit PR  = g < 3;
      localparam int CNW = $clog2(D+1);

      logic            rst, in_valid, in_ready, out_valid, out_ready, hold_i, flush_i;
      logic [7:0]      in_ctrl, out_ctrl;
      logic [15:0]     in_data, out_data;
      logic [CNW-1:0]  count_o;
      bit              active;
      bit              exp_rdy;
      logic [23:0]     q [$];

      ysyx_23060072_stage_buffer #(
         .CTRL_W(8), .DATA_W(16), .DEPTH(D), .CTRL_BUBBLE(BUB), .PASS_READY(PR)
      ) dut (
         .clk(clk), .rst(rst),
         .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
         .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
         .hold_i(hold_i), .flush_i(flush_i), .count_o(count_o)
      );

      // driver: randomised stimulus per phase, pushes accepted entries into the expected queue
      initial begin
         active = 1'b0;
         rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
         in_ctrl = '0; in_data = '0;
         @(negedge clk);
         @(negedge clk);
         rst = 1'b0;
         #1;
         chk("rst_out_valid", g, 32'(out_valid), 0);
         chk("rst_out_ctrl", g, 32'(out_ctrl), 32'(BUB));
         chk("rst_out_data", g, 32'(out_data), 0);
         chk("rst_count", g, 32'(count_o), 0);
         chk("rst_in_ready", g, 32'(in_ready), 1);
         active = 1'b1;
         for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 300; n++) begin
               @(negedge clk);
               in_ctrl = 8'($urandom);
               in_data = 16'($urandom);
               rst = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
               case (p)
                  0: begin in_valid = $urandom_range(0, 3) != 0; out_ready = 1'b1; end
                  1: begin in_valid = $urandom_range(0, 9) != 0; out_ready = $urandom_range(0, 9) == 0; end
                  2: begin in_valid = $urandom_range(0, 1) != 0; out_ready = n[0]; end
                  default: begin
                     in_valid  = $urandom_range(0, 1) != 0;
                     out_ready = $urandom_range(0, 1) != 0;
                     hold_i    = $urandom_range(0, 6) == 0;
                     flush_i   = $urandom_range(0, 19) == 0;
                     rst       = $urandom_range(0, 49) == 0;
                  end
               endcase
               #1;
               exp_rdy = !hold_i && !flush_i && (q.size() < D || (PR && q.size() == D && out_ready));
               chk("in_ready", g, 32'(in_ready), 32'(exp_rdy));
               #2;
               if (rst || flush_i) q.delete();
               else if (in_valid && exp_rdy) q.push_back({in_ctrl, in_data});
            end
         end
         @(negedge clk);
         active = 1'b0;
         in_valid = 1'b0; out_ready = 1'b0; hold_i = 1'b0; flush_i = 1'b0; rst = 1'b0;
         done_cnt++;
      end

      // monitor: compares the presented head against the queue front and retires it on a consume
      initial begin
         forever begin
            @(negedge clk);
            #2;
            if (active) begin
               chk("count", g, 32'(count_o), q.size());
               chk("out_valid", g, 32'(out_valid), 32'(q.size() != 0));
               if (q.size() != 0) begin
                  chk("out_ctrl", g, 32'(out_ctrl), 32'(q[0][23:16]));
                  chk("out_data", g, 32'(out_data), 32'(q[0][15:0]));
                  if (out_ready && !hold_i) void'(q.pop_front());
               end else begin
                  chk("out_ctrl_bubble", g, 32'(out_ctrl), 32'(BUB));
               end
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         if (done_cnt == NCFG) break;
      end
      if (done_cnt != NCFG) begin
         checks++;
         errors++;
         $display("FAIL timeout done=%0d expected=%0d", done_cnt, NCFG);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
